float_copro_sched: RTL

- Two-requester scheduler for the shared single-precision float datapath (float_copro_dp, combinational, opcode/op0/op1 -> result).
- Arbitrates round-robin, registers the operands, and drives them to the datapath for an opcode-dependent number of cycles.
- Captures the result and holds it for the owning requester until that requester accepts it.
- Requester handshake is valid/complete/accept, as used by the LM32 coprocessor interface.

---
 rtl/float_copro_pkg.sv | 37 +++
 rtl/copro_rr_arb.sv | 20 ++
 rtl/float_copro_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/float_copro_pkg.sv
// Shared definitions for the float coprocessor scheduler: opcodes, the
// quiet-NaN returned for illegal operations, FSM states and the latency map.
package float_copro_pkg;

    localparam logic [10:0] OP_FADD = 11'd0;
    localparam logic [10:0] OP_FSUB = 11'd1;
    localparam logic [10:0] OP_FMUL = 11'd2;
    localparam logic [10:0] OP_FDIV = 11'd3;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } sched_state_t;

    // Number of EXEC cycles for an opcode; illegal opcodes take one cycle.
    function automatic logic [4:0] op_latency(
        input logic [10:0] opcode,
        input logic [4:0]  cyc_add,
        input logic [4:0]  cyc_mul,
        input logic [4:0]  cyc_div
    );
        case (opcode)
            OP_FADD, OP_FSUB: op_latency = cyc_add;
            OP_FMUL:          op_latency = cyc_mul;
            OP_FDIV:          op_latency = cyc_div;
            default:          op_latency = 5'd1;
        endcase
    endfunction

    function automatic logic op_illegal(input logic [10:0] opcode);
        op_illegal = (opcode > OP_FDIV);
    endfunction

endpackage

// File: rtl/copro_rr_arb.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not served last.
module copro_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       winner
);

    // Pick the winner and raise its one-hot grant while enabled.
    always_comb begin
        winner = (req == 2'b11) ? ~last_grant : req[1];
        grant  = '0;
        if (enable && (req != 2'b00)) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/float_copro_sched.sv
// Scheduler for the shared single-precision float datapath. Arbitrates two
// requesters, registers the winner's operands toward the datapath for an
// opcode-dependent number of cycles, and holds the result until accepted.
module float_copro_sched
    import float_copro_pkg::*;
#(
    parameter int unsigned CYCLE_ADD = 2,
    parameter int unsigned CYCLE_MUL = 1,
    parameter int unsigned CYCLE_DIV = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [10:0] req0_opcode,
    input  logic [31:0] req0_op0,
    input  logic [31:0] req0_op1,
    input  logic [10:0] req1_opcode,
    input  logic [31:0] req1_op0,
    input  logic [31:0] req1_op1,
    input  logic [1:0]  req_accept,
    output logic [1:0]  req_grant,
    output logic [1:0]  req_complete,
    output logic [31:0] req_result,
    output logic [10:0] dp_opcode,
    output logic [31:0] dp_op0,
    output logic [31:0] dp_op1,
    input  logic [31:0] dp_result,
    output logic        busy
);

    localparam logic [4:0] LAT_ADD = 5'(CYCLE_ADD);
    localparam logic [4:0] LAT_MUL = 5'(CYCLE_MUL);
    localparam logic [4:0] LAT_DIV = 5'(CYCLE_DIV);

    sched_state_t state_q, state_d;
    logic         owner_q;
    logic         last_grant_q;
    logic [4:0]   cnt_q;
    logic         illegal_q;
    logic [31:0]  result_q;

    logic         winner;
    logic         load;
    logic         capture;
    logic         release_owner;
    logic [10:0]  sel_opcode;
    logic [31:0]  sel_op0;
    logic [31:0]  sel_op1;

    copro_rr_arb u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (state_q == IDLE),
        .grant      (req_grant),
        .winner     (winner)
    );

    // Route the winning requester's operation toward the datapath registers.
    always_comb begin
        sel_opcode = winner ? req1_opcode : req0_opcode;
        sel_op0    = winner ? req1_op0    : req0_op0;
        sel_op1    = winner ? req1_op1    : req0_op1;
    end

    // Next-state logic and per-state strobes; complete follows the owner in DONE.
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        capture       = 1'b0;
        release_owner = 1'b0;
        req_complete  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    load    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!req_valid[owner_q]) begin
                    release_owner = 1'b1;
                    state_d       = IDLE;
                end else if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                req_complete[owner_q] = 1'b1;
                // Accept and valid-drop both end the transaction the same way.
                if (req_accept[owner_q] || !req_valid[owner_q]) begin
                    release_owner = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, counter and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            illegal_q    <= 1'b0;
            result_q     <= '0;
            dp_opcode    <= '0;
            dp_op0       <= '0;
            dp_op1       <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                dp_opcode <= sel_opcode;
                dp_op0    <= sel_op0;
                dp_op1    <= sel_op1;
                owner_q   <= winner;
                illegal_q <= op_illegal(sel_opcode);
                cnt_q     <= op_latency(sel_opcode, LAT_ADD, LAT_MUL, LAT_DIV) - 5'd1;
            end else if ((state_q == EXEC) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 5'd1;
            end
            if (capture) begin
                result_q <= illegal_q ? QNAN : dp_result;
            end
            if (release_owner) begin
                last_grant_q <= owner_q;
            end
        end
    end

    assign req_result = result_q;
    assign busy       = (state_q != IDLE);

endmodule
